// File: rtl/altair_pkg.sv
// Shared definitions for the PU issue path: NOP opcode, controller state
// encoding, trap-cause codes and the register-number payload.
package altair_pkg;

   localparam int unsigned REG_W        = 5;
   localparam int unsigned OPCODE_MAX_W = 32;
   localparam int unsigned STATE_W      = 2;
   localparam int unsigned CAUSE_W      = 2;

   // All-zero opcode: no PU claims it, so no PU raises write-enable.
   localparam logic [OPCODE_MAX_W-1:0] OPCODE_NOP = '0;

   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
   localparam logic [STATE_W-1:0] ST_WAIT  = 2'd2;
   localparam logic [STATE_W-1:0] ST_TRAP  = 2'd3;

   localparam logic [CAUSE_W-1:0] TRAP_NONE    = 2'd0;
   localparam logic [CAUSE_W-1:0] TRAP_ILLEGAL = 2'd1;
   localparam logic [CAUSE_W-1:0] TRAP_TIMEOUT = 2'd2;

   typedef struct packed {
      logic [REG_W-1:0] rega;
      logic [REG_W-1:0] regb;
      logic [REG_W-1:0] regd;
   } pu_regs_t;

   localparam pu_regs_t REGS_NONE = '0;

endpackage

// File: rtl/pu_issue_ctrl_if.sv
// Upstream handshake, chain bus, trap and counter signals of the issue
// controller. master = the controller, slave = its environment.
interface pu_issue_ctrl_if
   import altair_pkg::*;
#(
   parameter int unsigned OW = 6,
   parameter int unsigned CW = 32
) ();

   logic               i_instr_valid;
   logic               o_instr_ready;
   logic [OW-1:0]      i_opcode;
   logic [REG_W-1:0]   i_rega;
   logic [REG_W-1:0]   i_regb;
   logic [REG_W-1:0]   i_regd;

   logic [OW-1:0]      o_opcode;
   logic [REG_W-1:0]   o_rega;
   logic [REG_W-1:0]   o_regb;
   logic [REG_W-1:0]   o_regd;

   logic               i_chain_ack;
   logic               i_chain_multi;
   logic               i_chain_done;

   logic               o_retire;
   logic               o_trap;
   logic [CAUSE_W-1:0] o_trap_cause;
   logic               i_trap_clr;
   logic [CW-1:0]      o_retired_cnt;
   logic [CW-1:0]      o_illegal_cnt;

   modport master (
      input  i_instr_valid, i_opcode, i_rega, i_regb, i_regd,
      input  i_chain_ack, i_chain_multi, i_chain_done, i_trap_clr,
      output o_instr_ready, o_opcode, o_rega, o_regb, o_regd,
      output o_retire, o_trap, o_trap_cause, o_retired_cnt, o_illegal_cnt
   );

   modport slave (
      output i_instr_valid, i_opcode, i_rega, i_regb, i_regd,
      output i_chain_ack, i_chain_multi, i_chain_done, i_trap_clr,
      input  o_instr_ready, o_opcode, o_rega, o_regb, o_regd,
      input  o_retire, o_trap, o_trap_cause, o_retired_cnt, o_illegal_cnt
   );

endinterface

// File: rtl/pu_issue_hold.sv
// Instruction hold register that drives the chain bus: loads an accepted
// instruction and falls back to NOP when the issue ends.
module pu_issue_hold
   import altair_pkg::*;
#(
   parameter int unsigned OW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          nop_sel,
   input  logic [OW-1:0] opcode_in,
   input  pu_regs_t      regs_in,
   output logic [OW-1:0] opcode,
   output pu_regs_t      regs
);

   // load has priority; both are never raised together by the controller
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode <= OW'(OPCODE_NOP);
         regs   <= REGS_NONE;
      end else if (load) begin
         opcode <= opcode_in;
         regs   <= regs_in;
      end else if (nop_sel) begin
         opcode <= OW'(OPCODE_NOP);
         regs   <= REGS_NONE;
      end
   end

endmodule

// File: rtl/pu_issue_ctrl.sv
// Issue sequencer for the PU chain: holds one instruction on the bus until a
// PU completes it, trapping on unclaimed opcodes and multi-cycle timeouts.
module pu_issue_ctrl
   import altair_pkg::*;
#(
   parameter int unsigned OPTION_OPCODE_WIDTH = 6,
   parameter int unsigned OPTION_TIMEOUT      = 255,
   parameter int unsigned OPTION_CNT_WIDTH    = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   pu_issue_ctrl_if.master bus
);

   localparam int unsigned OW    = OPTION_OPCODE_WIDTH;
   localparam int unsigned CW    = OPTION_CNT_WIDTH;
   localparam int unsigned TMO_W = $clog2(OPTION_TIMEOUT + 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
   logic               ready_q;
   logic               retire_q, retire_d;
   logic               trap_q, trap_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic               ill_inc;
   logic               load, nop_sel;
   logic [CW-1:0]      retired_cnt, illegal_cnt;
   logic [OW-1:0]      hold_opcode;
   pu_regs_t           hold_regs;
   pu_regs_t           regs_in;

   assign regs_in = {bus.i_rega, bus.i_regb, bus.i_regd};

   pu_issue_hold #(.OW(OW)) u_hold (
      .clk       (i_clk),
      .rst_n     (i_rst),
      .load      (load),
      .nop_sel   (nop_sel),
      .opcode_in (bus.i_opcode),
      .regs_in   (regs_in),
      .opcode    (hold_opcode),
      .regs      (hold_regs)
   );

   // State and registered control outputs
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= ST_IDLE;
         tmo_q    <= '0;
         ready_q  <= 1'b0;
         retire_q <= 1'b0;
         trap_q   <= 1'b0;
         cause_q  <= TRAP_NONE;
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         ready_q  <= (state_d == ST_IDLE);
         retire_q <= retire_d;
         trap_q   <= trap_d;
         cause_q  <= cause_d;
      end
   end

   // Next-state logic; ready is only offered once the IDLE register is live
   always_comb begin
      state_d  = state_q;
      tmo_d    = tmo_q;
      trap_d   = trap_q;
      cause_d  = cause_q;
      retire_d = 1'b0;
      ill_inc  = 1'b0;
      load     = 1'b0;
      nop_sel  = 1'b0;
      tmo_inc  = tmo_q + TMO_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (bus.i_instr_valid && ready_q) begin
               load    = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!bus.i_chain_ack) begin
               trap_d  = 1'b1;
               cause_d = TRAP_ILLEGAL;
               ill_inc = 1'b1;
               nop_sel = 1'b1;
               state_d = ST_TRAP;
            end else if (!bus.i_chain_multi || bus.i_chain_done) begin
               retire_d = 1'b1;
               nop_sel  = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               tmo_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.i_chain_done) begin
               retire_d = 1'b1;
               nop_sel  = 1'b1;
               state_d  = ST_IDLE;
            end else if (tmo_inc == TMO_W'(OPTION_TIMEOUT)) begin
               trap_d  = 1'b1;
               cause_d = TRAP_TIMEOUT;
               nop_sel = 1'b1;
               state_d = ST_TRAP;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         ST_TRAP: begin
            if (bus.i_trap_clr) begin
               trap_d  = 1'b0;
               cause_d = TRAP_NONE;
               state_d = ST_IDLE;
            end
         end
         default: begin
            nop_sel = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Retired count wraps; illegal count sticks at all-ones
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         retired_cnt <= '0;
         illegal_cnt <= '0;
      end else begin
         if (retire_d)
            retired_cnt <= retired_cnt + CW'(1);
         if (ill_inc && (illegal_cnt != {CW{1'b1}}))
            illegal_cnt <= illegal_cnt + CW'(1);
      end
   end

   assign bus.o_instr_ready = ready_q;
   assign bus.o_opcode      = hold_opcode;
   assign bus.o_rega        = hold_regs.rega;
   assign bus.o_regb        = hold_regs.regb;
   assign bus.o_regd        = hold_regs.regd;
   assign bus.o_retire      = retire_q;
   assign bus.o_trap        = trap_q;
   assign bus.o_trap_cause  = cause_q;
   assign bus.o_retired_cnt = retired_cnt;
   assign bus.o_illegal_cnt = illegal_cnt;

endmodule

// File: tb/tb_pu_issue_ctrl.sv
// Bench for pu_issue_ctrl: directed scenarios plus random instructions scored
// against an outcome model (retire / illegal / timeout) and counter model.
module tb_pu_issue_ctrl;

   localparam int unsigned OW      = 6;
   localparam int unsigned TMO     = 4;
   localparam int unsigned CW      = 4;
   localparam int unsigned BW      = OW + 15;
   localparam int          CNT_MOD = 1 << CW;
   localparam int          CNT_MAX = CNT_MOD - 1;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   m_ret = 0;
   int   m_ill = 0;

   pu_issue_ctrl_if #(.OW(OW), .CW(CW)) bus_if ();

   pu_issue_ctrl #(
      .OPTION_OPCODE_WIDTH (OW),
      .OPTION_TIMEOUT      (TMO),
      .OPTION_CNT_WIDTH    (CW)
   ) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [BW-1:0] bus_word();
      return {bus_if.o_opcode, bus_if.o_rega, bus_if.o_regb, bus_if.o_regd};
   endfunction

   task automatic quiet_inputs();
      bus_if.i_instr_valid = 1'b0;
      {bus_if.i_opcode, bus_if.i_rega, bus_if.i_regb, bus_if.i_regd} = '0;
      bus_if.i_chain_ack   = 1'b0;
      bus_if.i_chain_multi = 1'b0;
      bus_if.i_chain_done  = 1'b0;
      bus_if.i_trap_clr    = 1'b0;
   endtask

   // One instruction end to end; outcome derived from the chain script:
   // done_at = WAIT cycle on which done rises (0 = in ISSUE, <0 = never).
   task automatic run_instr(input logic [OW-1:0] op, input logic [14:0] regs,
                            input logic ack, input logic multi, input int done_at,
                            input string tag);
      int outcome;
      int nbus;
      int n;
      logic [BW-1:0] want;
      logic [4:0] want_flags;
      want = {op, regs};
      if (!ack) begin
         outcome = 1; nbus = 1;
      end else if (!multi || done_at == 0) begin
         outcome = 0; nbus = 1;
      end else if (done_at > 0 && done_at <= TMO) begin
         outcome = 0; nbus = 1 + done_at;
      end else begin
         outcome = 2; nbus = 1 + TMO;
      end

      n = 0;
      while (bus_if.o_instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk); n++;
      end
      total++;
      if (bus_if.o_instr_ready !== 1'b1) begin
         bad++; $display("FAIL %s ready_wait: got %b want 1", tag, bus_if.o_instr_ready);
      end

      bus_if.i_instr_valid = 1'b1;
      {bus_if.i_opcode, bus_if.i_rega, bus_if.i_regb, bus_if.i_regd} = want;
      @(negedge clk);
      bus_if.i_instr_valid = 1'b0;
      {bus_if.i_opcode, bus_if.i_rega, bus_if.i_regb, bus_if.i_regd} = BW'($urandom);

      for (int c = 1; c <= nbus; c++) begin
         total++;
         if (bus_word() !== want) begin
            bad++; $display("FAIL %s bus_hold c=%0d: got %h want %h", tag, c, bus_word(), want);
         end
         total++;
         if ({bus_if.o_retire, bus_if.o_trap, bus_if.o_instr_ready} !== 3'b000) begin
            bad++; $display("FAIL %s busy_flags c=%0d: got %b want 000", tag, c,
                            {bus_if.o_retire, bus_if.o_trap, bus_if.o_instr_ready});
         end
         bus_if.i_chain_ack   = ack;
         bus_if.i_chain_multi = ack ? multi : 1'($urandom);
         bus_if.i_chain_done  = (ack && multi) ? (c == done_at + 1) : 1'($urandom);
         bus_if.i_trap_clr    = 1'($urandom);
         @(negedge clk);
      end
      bus_if.i_chain_ack   = 1'b0;
      bus_if.i_chain_multi = 1'b0;
      bus_if.i_chain_done  = 1'b0;
      bus_if.i_trap_clr    = 1'b0;

      if (outcome == 0) m_ret = (m_ret + 1) % CNT_MOD;
      if (outcome == 1 && m_ill < CNT_MAX) m_ill = m_ill + 1;
      case (outcome)
         0:       want_flags = 5'b1_0_00_1;
         1:       want_flags = 5'b0_1_01_0;
         default: want_flags = 5'b0_1_10_0;
      endcase

      total++;
      if (bus_word() !== '0) begin
         bad++; $display("FAIL %s bus_nop: got %h want 0", tag, bus_word());
      end
      total++;
      if ({bus_if.o_retire, bus_if.o_trap, bus_if.o_trap_cause, bus_if.o_instr_ready} !== want_flags) begin
         bad++; $display("FAIL %s end_flags: got %b want %b", tag,
                         {bus_if.o_retire, bus_if.o_trap, bus_if.o_trap_cause, bus_if.o_instr_ready}, want_flags);
      end
      total++;
      if ({bus_if.o_retired_cnt, bus_if.o_illegal_cnt} !== {CW'(m_ret), CW'(m_ill)}) begin
         bad++; $display("FAIL %s counters: got ret=%0d ill=%0d want ret=%0d ill=%0d", tag,
                         bus_if.o_retired_cnt, bus_if.o_illegal_cnt, m_ret, m_ill);
      end

      if (outcome != 0) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         bus_if.i_trap_clr = 1'b1;
         @(negedge clk);
         bus_if.i_trap_clr = 1'b0;
         total++;
         if ({bus_if.o_retire, bus_if.o_trap, bus_if.o_trap_cause, bus_if.o_instr_ready} !== 5'b0_0_00_1) begin
            bad++; $display("FAIL %s trap_clear: got %b want 00001", tag,
                            {bus_if.o_retire, bus_if.o_trap, bus_if.o_trap_cause, bus_if.o_instr_ready});
         end
      end else begin
         @(negedge clk);
         total++;
         if ({bus_if.o_retire, bus_if.o_trap, bus_if.o_instr_ready} !== 3'b001) begin
            bad++; $display("FAIL %s retire_pulse: got %b want 001", tag,
                            {bus_if.o_retire, bus_if.o_trap, bus_if.o_instr_ready});
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      quiet_inputs();
      repeat (2) @(negedge clk);
      total++;
      if ({bus_if.o_instr_ready, bus_if.o_retire, bus_if.o_trap, bus_if.o_trap_cause,
           bus_if.o_retired_cnt, bus_if.o_illegal_cnt, bus_word()} !== '0) begin
         bad++; $display("FAIL reset_values: got rdy=%b ret=%b trap=%b cause=%0d rc=%0d ic=%0d bus=%h want all 0",
                         bus_if.o_instr_ready, bus_if.o_retire, bus_if.o_trap, bus_if.o_trap_cause,
                         bus_if.o_retired_cnt, bus_if.o_illegal_cnt, bus_word());
      end
      rst_n = 1'b1;
      m_ret = 0;
      m_ill = 0;
   endtask

   task automatic test_single_and();
      run_instr(6'b000100, 15'h1234, 1'b1, 1'b0, 0, "and_single");
   endtask

   task automatic test_illegal();
      run_instr(6'b111111, 15'h0abc, 1'b0, 1'b0, 0, "illegal");
   endtask

   task automatic test_multi();
      run_instr(6'b001010, 15'h4321, 1'b1, 1'b1, 4, "multi_5cyc");
      run_instr(6'b001011, 15'h0011, 1'b1, 1'b1, 0, "multi_done_in_issue");
   endtask

   task automatic test_timeout();
      run_instr(6'b001100, 15'h7001, 1'b1, 1'b1, -1, "tmo_never");
      run_instr(6'b001101, 15'h7002, 1'b1, 1'b1, TMO, "tmo_done_last");
      run_instr(6'b001110, 15'h7003, 1'b1, 1'b1, TMO + 1, "tmo_done_late");
   endtask

   task automatic test_reset_in_wait();
      int n;
      n = 0;
      while (bus_if.o_instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk); n++;
      end
      bus_if.i_instr_valid = 1'b1;
      {bus_if.i_opcode, bus_if.i_rega, bus_if.i_regb, bus_if.i_regd} = {6'b010101, 15'h2a2a};
      @(negedge clk);
      bus_if.i_instr_valid = 1'b0;
      bus_if.i_chain_ack   = 1'b1;
      bus_if.i_chain_multi = 1'b1;
      bus_if.i_chain_done  = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bus_if.o_instr_ready, bus_if.o_retire, bus_if.o_trap, bus_if.o_trap_cause,
           bus_if.o_retired_cnt, bus_if.o_illegal_cnt, bus_word()} !== '0) begin
         bad++; $display("FAIL async_reset: got rdy=%b ret=%b trap=%b cause=%0d rc=%0d ic=%0d bus=%h want all 0",
                         bus_if.o_instr_ready, bus_if.o_retire, bus_if.o_trap, bus_if.o_trap_cause,
                         bus_if.o_retired_cnt, bus_if.o_illegal_cnt, bus_word());
      end
      bus_if.i_chain_done = 1'b1;
      @(negedge clk);
      total++;
      if ({bus_if.o_retire, bus_if.o_instr_ready} !== 2'b00) begin
         bad++; $display("FAIL reset_hold: got ret=%b rdy=%b want 0 0", bus_if.o_retire, bus_if.o_instr_ready);
      end
      quiet_inputs();
      rst_n = 1'b1;
      m_ret = 0;
      m_ill = 0;
      run_instr(6'b000100, 15'h0555, 1'b1, 1'b0, 0, "after_reset");
   endtask

   task automatic test_back_to_back();
      logic [BW-1:0] w [4];
      int k;
      int retires;
      int n;
      logic acc;
      for (int i = 0; i < 4; i++) w[i] = {6'b000101, 15'($urandom)};
      n = 0;
      while (bus_if.o_instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk); n++;
      end
      bus_if.i_chain_ack   = 1'b1;
      bus_if.i_chain_multi = 1'b0;
      bus_if.i_chain_done  = 1'b0;
      k = 0;
      retires = 0;
      bus_if.i_instr_valid = 1'b1;
      {bus_if.i_opcode, bus_if.i_rega, bus_if.i_regb, bus_if.i_regd} = w[0];
      for (int t = 1; t <= 8; t++) begin
         acc = bus_if.i_instr_valid && bus_if.o_instr_ready;
         @(negedge clk);
         if (bus_if.o_retire === 1'b1) retires++;
         if (acc) begin
            total++;
            if (bus_word() !== w[k]) begin
               bad++; $display("FAIL b2b_bus k=%0d: got %h want %h", k, bus_word(), w[k]);
            end
            k++;
            if (k < 4) {bus_if.i_opcode, bus_if.i_rega, bus_if.i_regb, bus_if.i_regd} = w[k];
            else bus_if.i_instr_valid = 1'b0;
         end
      end
      quiet_inputs();
      total++;
      if (k != 4 || retires != 4) begin
         bad++; $display("FAIL b2b_throughput: got accepts=%0d retires=%0d want 4 4", k, retires);
      end
      m_ret = (m_ret + 4) % CNT_MOD;
      @(negedge clk);
      total++;
      if ({bus_if.o_retire, bus_if.o_retired_cnt} !== {1'b0, CW'(m_ret)}) begin
         bad++; $display("FAIL b2b_count: got ret=%b cnt=%0d want 0 %0d", bus_if.o_retire, bus_if.o_retired_cnt, m_ret);
      end
   endtask

   task automatic test_trap_clr_idle();
      bus_if.i_trap_clr = 1'b1;
      @(negedge clk);
      bus_if.i_trap_clr = 1'b0;
      @(negedge clk);
      total++;
      if ({bus_if.o_trap, bus_if.o_trap_cause, bus_if.o_instr_ready, bus_word()} !== {4'b0001, BW'(0)}) begin
         bad++; $display("FAIL clr_in_idle: got trap=%b cause=%0d rdy=%b bus=%h want 0 0 1 0",
                         bus_if.o_trap, bus_if.o_trap_cause, bus_if.o_instr_ready, bus_word());
      end
   endtask

   task automatic test_counters();
      int guard;
      guard = 0;
      while (m_ret != CNT_MAX && guard < CNT_MOD) begin
         run_instr(6'b000110, 15'($urandom), 1'b1, 1'b0, 0, "fill_ret");
         guard++;
      end
      run_instr(6'b000110, 15'($urandom), 1'b1, 1'b0, 0, "wrap_ret");
      total++;
      if (bus_if.o_retired_cnt !== CW'(0)) begin
         bad++; $display("FAIL retired_wrap: got %0d want 0", bus_if.o_retired_cnt);
      end
      repeat (CNT_MOD + 1) run_instr(6'b111110, 15'($urandom), 1'b0, 1'b0, 0, "sat_ill");
      total++;
      if (bus_if.o_illegal_cnt !== CW'(CNT_MAX)) begin
         bad++; $display("FAIL illegal_sat: got %0d want %0d", bus_if.o_illegal_cnt, CNT_MAX);
      end
   endtask

   task automatic test_random();
      logic [OW-1:0] op;
      logic ack;
      logic multi;
      int done_at;
      for (int i = 0; i < 60; i++) begin
         op      = OW'($urandom_range(1, (1 << OW) - 1));
         ack     = ($urandom % 4) != 0;
         multi   = 1'($urandom);
         done_at = $urandom_range(0, TMO + 2);
         if (done_at == TMO + 2) done_at = -1;
         run_instr(op, 15'($urandom), ack, multi, done_at, "random");
      end
   endtask

   initial begin
      rst_n = 1'b0;
      quiet_inputs();
      test_reset();
      test_single_and();
      test_illegal();
      test_multi();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
      test_trap_clr_idle();
      test_counters();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
